web_gen2_wake: RTL and testbench

- Parametrised next-generation wake-event block.
- Generalises the fixed 64-input invert/enable wake gate to NUM_INPUTS channels, each with:
  - per-channel trigger mode (level/rising/falling/both)
  - a shared programmable debounce filter
  - sticky W1C pending status
  - lowest-index wake-cause reporting
- wake has a guaranteed minimum assertion width. wake_now and event_suppress are software-set and cleared by a synchronised clear_function edge.
- Sits between the interrupt/GPIO aggregation and the EPU/power controller.

---
 rtl/web_gen2_pkg.sv | 28 ++
 rtl/web_gen2_wake_if.sv | 37 +++
 rtl/ftc_double_rank_synchronizer_async.sv | 30 +++
 rtl/web_gen2_wake_chan.sv | 91 +++++++++
 rtl/web_gen2_wake.sv | 145 ++++++++++++++
 tb/tb_web_gen2_wake.sv | 225 ++++++++++++++++++++++
 6 files changed

// File: rtl/web_gen2_pkg.sv
// web_gen2_pkg: shared types and default constants for the wake-event block.
//   trig_mode_e  : per-channel trigger selection
//   clear_edge_e : which clear_function edge clears the sticky software bits
//   cause_width  : width of a lowest-index cause code for n channels (min 1)
package web_gen2_pkg;

  typedef enum logic [1:0] {
    LEVEL = 2'd0,
    RISE  = 2'd1,
    FALL  = 2'd2,
    BOTH  = 2'd3
  } trig_mode_e;

  typedef enum logic [1:0] {
    CLR_FALL = 2'd0,
    CLR_RISE = 2'd1,
    CLR_NONE = 2'd2
  } clear_edge_e;

  localparam int DEF_NUM_INPUTS = 64;
  localparam int DEF_DEB_W      = 8;
  localparam int DEF_WAKE_HOLD  = 4;

  function automatic int cause_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/web_gen2_wake_if.sv
// web_gen2_wake_if: CSR, event and status bundle of the wake-event block.
//   master : the aggregation/CSR side driving sources and controls
//   slave  : the wake block, returning pending/int_out/wake status
interface web_gen2_wake_if #(
  parameter int NUM_INPUTS = web_gen2_pkg::DEF_NUM_INPUTS,
  parameter int DEB_W      = web_gen2_pkg::DEF_DEB_W,
  parameter int CAUSE_W    = web_gen2_pkg::cause_width(NUM_INPUTS)
);
  logic [NUM_INPUTS-1:0]   int_in;
  logic [NUM_INPUTS-1:0]   enable;
  logic [NUM_INPUTS-1:0]   invert;
  logic [2*NUM_INPUTS-1:0] mode;
  logic [DEB_W-1:0]        deb_cycles;
  logic [NUM_INPUTS-1:0]   pending_clr;
  logic                    wake_now_set;
  logic                    suppress_set;
  logic [1:0]              clear_edge;
  logic                    clear_function;
  logic [NUM_INPUTS-1:0]   pending;
  logic [NUM_INPUTS-1:0]   int_out;
  logic                    wake;
  logic [CAUSE_W-1:0]      wake_cause;
  logic                    wake_now;
  logic                    event_suppress;

  modport master (
    output int_in, enable, invert, mode, deb_cycles, pending_clr,
           wake_now_set, suppress_set, clear_edge, clear_function,
    input  pending, int_out, wake, wake_cause, wake_now, event_suppress
  );

  modport slave (
    input  int_in, enable, invert, mode, deb_cycles, pending_clr,
           wake_now_set, suppress_set, clear_edge, clear_function,
    output pending, int_out, wake, wake_cause, wake_now, event_suppress
  );
endinterface

// File: rtl/ftc_double_rank_synchronizer_async.sv
// ftc_double_rank_synchronizer_async: two-flop synchroniser with test bypass.
//   clk, rst_n : capture clock, async active-low reset (ranks load RSTVAL)
//   test_mode  : 1 = pass d straight through (scan/test)
//   d / q      : asynchronous input / synchronised output
module ftc_double_rank_synchronizer_async #(
  parameter int               WIDTH  = 1,
  parameter logic [WIDTH-1:0] RSTVAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             test_mode,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] rank1_r;
  logic [WIDTH-1:0] rank2_r;

  // Two capture ranks resolve metastability before use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rank1_r <= RSTVAL;
      rank2_r <= RSTVAL;
    end else begin
      rank1_r <= d;
      rank2_r <= rank1_r;
    end
  end

  assign q = test_mode ? d : rank2_r;
endmodule

// File: rtl/web_gen2_wake_chan.sv
// web_gen2_chan: one wake channel.
//   int_in, invert : source and its polarity select (raw = int_in ^ invert)
//   deb_cycles     : shared debounce threshold, 0 = plain register
//   mode           : trigger select (trig_mode_e encoding)
//   enable         : event-to-pending gate
//   pending_clr    : W1C pulse; a same-cycle event wins
//   filt, pending  : registered filtered level and sticky status
module web_gen2_chan
  import web_gen2_pkg::*;
#(
  parameter int DEB_W = DEF_DEB_W
) (
  input  logic             clkclk,
  input  logic             sysreset_n,
  input  logic             int_in,
  input  logic             invert,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [DEB_W-1:0] deb_cycles,
  input  logic             pending_clr,
  output logic             filt,
  output logic             pending
);
  localparam logic [DEB_W-1:0] DEB_ONE = DEB_W'(1);
  localparam logic [DEB_W-1:0] DEB_MAX = {DEB_W{1'b1}};

  logic             raw_s;
  logic [DEB_W-1:0] thr_s;
  logic [DEB_W-1:0] cnt_r;
  logic [DEB_W-1:0] cnt_nxt_s;
  logic             filt_r;
  logic             filt_nxt_s;
  logic             filt_q_r;
  logic             event_s;
  logic             pending_r;
  logic             pending_nxt_s;
  trig_mode_e       mode_s;

  assign raw_s  = int_in ^ invert;
  assign mode_s = trig_mode_e'(mode);
  // A zero threshold collapses to "accept on the first mismatching sample".
  assign thr_s  = (deb_cycles == {DEB_W{1'b0}}) ? {DEB_W{1'b0}} : (deb_cycles - DEB_ONE);

  // Debounce: count mismatching samples, commit once the threshold is met.
  always_comb begin
    cnt_nxt_s  = cnt_r;
    filt_nxt_s = filt_r;
    if (raw_s == filt_r) begin
      cnt_nxt_s = {DEB_W{1'b0}};
    end else if (cnt_r >= thr_s) begin
      filt_nxt_s = raw_s;
      cnt_nxt_s  = {DEB_W{1'b0}};
    end else if (cnt_r != DEB_MAX) begin
      cnt_nxt_s = cnt_r + DEB_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Trigger selection on the filtered level and its one-cycle history.
  always_comb begin
    event_s = 1'b0;
    case (mode_s)
      LEVEL:   event_s = filt_r;
      RISE:    event_s = filt_r & ~filt_q_r;
      FALL:    event_s = ~filt_r & filt_q_r;
      BOTH:    event_s = filt_r ^ filt_q_r;
      default: event_s = 1'b0;
    endcase
  end

  assign pending_nxt_s = (pending_r & ~pending_clr) | (event_s & enable);

  // Channel state registers; filt_q starts at 0 so reset creates no edge.
  always_ff @(posedge clkclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      cnt_r     <= {DEB_W{1'b0}};
      filt_r    <= 1'b0;
      filt_q_r  <= 1'b0;
      pending_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_nxt_s;
      filt_r    <= filt_nxt_s;
      filt_q_r  <= filt_r;
      pending_r <= pending_nxt_s;
    end
  end

  assign filt    = filt_r;
  assign pending = pending_r;
endmodule

// File: rtl/web_gen2_wake.sv
// web_gen2_wake: parametrised wake-event block.
//   clkclk, sysreset_n  : sole clock, async active-low reset
//   systest_mode_async  : bypasses the clear_function synchroniser
//   bus (slave)         : sources, CSRs, W1C/set pulses, clear_function in;
//                         pending, int_out, wake, wake_cause, wake_now,
//                         event_suppress out
module web_gen2_wake
  import web_gen2_pkg::*;
#(
  parameter int NUM_INPUTS = DEF_NUM_INPUTS,
  parameter int DEB_W      = DEF_DEB_W,
  parameter int WAKE_HOLD  = DEF_WAKE_HOLD,
  parameter int CAUSE_W    = cause_width(NUM_INPUTS)
) (
  input  logic clkclk,
  input  logic sysreset_n,
  input  logic systest_mode_async,
  web_gen2_wake_if.slave bus
);
  localparam int               HOLD_W    = (WAKE_HOLD > 1) ? $clog2(WAKE_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(WAKE_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  logic [NUM_INPUTS-1:0] filt_s;
  logic [NUM_INPUTS-1:0] pending_s;
  logic                  sync_s;
  logic                  sync_q_r;
  logic                  rise_s;
  logic                  fall_s;
  logic                  clr_s;
  logic                  wake_now_r;
  logic                  supp_r;
  logic                  wake_req_s;
  logic                  wake_r;
  logic [HOLD_W-1:0]     hold_r;
  logic [CAUSE_W-1:0]    cause_r;

  function automatic logic [CAUSE_W-1:0] lowest_index(input logic [NUM_INPUTS-1:0] v);
    logic [CAUSE_W-1:0] idx;
    idx = {CAUSE_W{1'b0}};
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = CAUSE_W'(i);
      end
    end
    return idx;
  endfunction

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_chan
    web_gen2_chan #(.DEB_W(DEB_W)) u_chan (
      .clkclk      (clkclk),
      .sysreset_n  (sysreset_n),
      .int_in      (bus.int_in[g]),
      .invert      (bus.invert[g]),
      .enable      (bus.enable[g]),
      .mode        (bus.mode[2*g +: 2]),
      .deb_cycles  (bus.deb_cycles),
      .pending_clr (bus.pending_clr[g]),
      .filt        (filt_s[g]),
      .pending     (pending_s[g])
    );
  end

  ftc_double_rank_synchronizer_async #(.WIDTH(1), .RSTVAL(1'b0)) u_clr_sync (
    .clk       (clkclk),
    .rst_n     (sysreset_n),
    .test_mode (systest_mode_async),
    .d         (bus.clear_function),
    .q         (sync_s)
  );

  assign rise_s = sync_s & ~sync_q_r;
  assign fall_s = ~sync_s & sync_q_r;

  // Pick which synchronised clear_function edge acts as the clear strobe.
  always_comb begin
    clr_s = 1'b0;
    case (clear_edge_e'(bus.clear_edge))
      CLR_FALL: clr_s = fall_s;
      CLR_RISE: clr_s = rise_s;
      CLR_NONE: clr_s = 1'b0;
      default:  clr_s = 1'b0;
    endcase
  end

  // Sticky software bits; a set pulse beats a simultaneous clear.
  always_ff @(posedge clkclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      sync_q_r   <= 1'b0;
      wake_now_r <= 1'b0;
      supp_r     <= 1'b0;
    end else begin
      sync_q_r <= sync_s;
      if (bus.wake_now_set) begin
        wake_now_r <= 1'b1;
      end else if (clr_s) begin
        wake_now_r <= 1'b0;
      end else begin
        wake_now_r <= wake_now_r;
      end
      if (bus.suppress_set) begin
        supp_r <= 1'b1;
      end else if (clr_s) begin
        supp_r <= 1'b0;
      end else begin
        supp_r <= supp_r;
      end
    end
  end

  assign wake_req_s = (|pending_s) | wake_now_r;

  // Wake with minimum width: any request reloads the hold count.
  always_ff @(posedge clkclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      wake_r <= 1'b0;
      hold_r <= {HOLD_W{1'b0}};
    end else if (wake_req_s) begin
      wake_r <= 1'b1;
      hold_r <= HOLD_LOAD;
    end else if (hold_r != {HOLD_W{1'b0}}) begin
      wake_r <= 1'b1;
      hold_r <= hold_r - HOLD_ONE;
    end else begin
      wake_r <= 1'b0;
      hold_r <= hold_r;
    end
  end

  // Registered lowest-index cause of the current pending vector.
  always_ff @(posedge clkclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      cause_r <= {CAUSE_W{1'b0}};
    end else begin
      cause_r <= lowest_index(pending_s);
    end
  end

  assign bus.pending        = pending_s;
  assign bus.int_out        = filt_s & {NUM_INPUTS{~supp_r}};
  assign bus.wake           = wake_r;
  assign bus.wake_cause     = cause_r;
  assign bus.wake_now       = wake_now_r;
  assign bus.event_suppress = supp_r;
endmodule

// File: tb/tb_web_gen2_wake.sv
module tb_web_gen2_wake;
  import web_gen2_pkg::*;

  localparam int N  = 16;
  localparam int DW = 8;
  localparam int WH = 4;
  localparam int CW = 4;

  logic clkclk = 1'b0;
  logic sysreset_n;
  logic systest_mode_async;

  always #5 clkclk = ~clkclk;

  web_gen2_wake_if #(.NUM_INPUTS(N), .DEB_W(DW), .CAUSE_W(CW)) bus ();

  web_gen2_wake #(.NUM_INPUTS(N), .DEB_W(DW), .WAKE_HOLD(WH), .CAUSE_W(CW)) dut (
    .clkclk             (clkclk),
    .sysreset_n         (sysreset_n),
    .systest_mode_async (systest_mode_async),
    .bus                (bus)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural reference state.
  bit [N-1:0]  m_filt, m_filtq, m_pend, m_last_raw;
  int          m_run [N];
  bit          m_wnow, m_supp, m_wake;
  int          m_since;
  bit [CW-1:0] m_cause;
  bit          cf1, cf2, cf3;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_filt = '0; m_filtq = '0; m_pend = '0; m_last_raw = '0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
    m_wnow = 1'b0; m_supp = 1'b0; m_wake = 1'b0; m_since = 1000;
    m_cause = '0; cf1 = 1'b0; cf2 = 1'b0; cf3 = 1'b0;
  endtask

  // One clock edge of the reference, using pre-edge state and current inputs.
  task automatic m_step();
    bit         req, clr, r;
    bit [N-1:0] raw, ev, nf;
    int         thr;
    req     = (|m_pend) | m_wnow;
    m_since = req ? 0 : ((m_since < 1000) ? m_since + 1 : m_since);
    m_wake  = (m_since < WH);
    m_cause = '0;
    for (int i = N - 1; i >= 0; i--) if (m_pend[i]) m_cause = CW'(i);
    for (int i = 0; i < N; i++) begin
      case (bus.mode[2*i +: 2])
        2'd0:    ev[i] = m_filt[i];
        2'd1:    ev[i] = m_filt[i] & ~m_filtq[i];
        2'd2:    ev[i] = ~m_filt[i] & m_filtq[i];
        default: ev[i] = m_filt[i] ^ m_filtq[i];
      endcase
    end
    m_pend = (m_pend & ~bus.pending_clr) | (ev & bus.enable);
    // clear_function reaches the edge detector three samples late.
    case (bus.clear_edge)
      2'd0:    clr = ~cf2 & cf3;
      2'd1:    clr = cf2 & ~cf3;
      default: clr = 1'b0;
    endcase
    cf3 = cf2; cf2 = cf1; cf1 = bus.clear_function;
    m_wnow = bus.wake_now_set ? 1'b1 : (clr ? 1'b0 : m_wnow);
    m_supp = bus.suppress_set ? 1'b1 : (clr ? 1'b0 : m_supp);
    raw = bus.int_in ^ bus.invert;
    thr = (bus.deb_cycles == 0) ? 1 : int'(bus.deb_cycles);
    for (int i = 0; i < N; i++) begin
      r = raw[i];
      m_run[i] = (r == m_last_raw[i]) ? m_run[i] + 1 : 1;
      m_last_raw[i] = r;
      nf[i] = (r != m_filt[i] && m_run[i] >= thr) ? r : m_filt[i];
    end
    m_filtq = m_filt;
    m_filt  = nf;
  endtask

  task automatic check_all();
    chk("pending", bus.pending, m_pend);
    chk("int_out", bus.int_out, m_filt & ~{N{m_supp}});
    chk("wake", bus.wake, m_wake);
    chk("wake_cause", bus.wake_cause, m_cause);
    chk("wake_now", bus.wake_now, m_wnow);
    chk("event_suppress", bus.event_suppress, m_supp);
  endtask

  task automatic cyc();
    @(posedge clkclk);
    m_step();
    #1;
    check_all();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pending"}, bus.pending, 64'd0);
    chk({tag, "_int_out"}, bus.int_out, 64'd0);
    chk({tag, "_wake"}, bus.wake, 64'd0);
    chk({tag, "_cause"}, bus.wake_cause, 64'd0);
    chk({tag, "_wake_now"}, bus.wake_now, 64'd0);
    chk({tag, "_suppress"}, bus.event_suppress, 64'd0);
  endtask

  initial begin
    logic [N-1:0] flip;
    sysreset_n = 1'b0; systest_mode_async = 1'b0;
    bus.int_in = '0; bus.enable = '0; bus.invert = '0; bus.mode = '0;
    bus.deb_cycles = '0; bus.pending_clr = '0; bus.wake_now_set = 1'b0;
    bus.suppress_set = 1'b0; bus.clear_edge = 2'd1; bus.clear_function = 1'b0;
    m_reset();
    repeat (2) @(posedge clkclk);
    #1;
    check_zero("reset");
    sysreset_n = 1'b1;
    cyc();

    // Debounce: a 2-cycle glitch is rejected at deb=3, a 3-cycle level passes.
    bus.deb_cycles = 8'd3; bus.mode[1:0] = 2'd1; bus.enable[0] = 1'b1;
    bus.int_in[0] = 1'b1; cyc(); cyc();
    bus.int_in[0] = 1'b0; repeat (4) cyc();
    chk("glitch_pending0", bus.pending[0], 1'b0);
    bus.int_in[0] = 1'b1; cyc(); cyc();
    chk("filt_not_yet", bus.int_out[0], 1'b0);
    cyc();
    chk("filt_after_3", bus.int_out[0], 1'b1);
    cyc();
    chk("pending0_set", bus.pending[0], 1'b1);
    cyc();
    chk("wake_after_pend", bus.wake, 1'b1);
    chk("cause0", bus.wake_cause, 64'd0);
    bus.pending_clr[0] = 1'b1; cyc(); bus.pending_clr[0] = 1'b0;
    repeat (6) cyc();

    // Priority cause and wake hold.
    bus.deb_cycles = 8'd0;
    bus.mode[11:10] = 2'd3; bus.mode[19:18] = 2'd3;
    bus.enable[5] = 1'b1; bus.enable[9] = 1'b1;
    bus.int_in[5] = 1'b1; bus.int_in[9] = 1'b1;
    repeat (3) cyc();
    chk("cause5", bus.wake_cause, 64'd5);
    bus.pending_clr[5] = 1'b1; cyc(); bus.pending_clr[5] = 1'b0;
    cyc();
    chk("cause9", bus.wake_cause, 64'd9);
    bus.pending_clr[9] = 1'b1; cyc(); bus.pending_clr[9] = 1'b0;
    cyc(); cyc(); cyc();
    chk("wake_held3", bus.wake, 1'b1);
    cyc();
    chk("wake_dropped4", bus.wake, 1'b0);

    // Set beats clear on channel 3.
    bus.mode[7:6] = 2'd1; bus.enable[3] = 1'b1;
    bus.int_in[3] = 1'b1; cyc(); cyc();
    bus.int_in[3] = 1'b0; cyc(); cyc();
    bus.int_in[3] = 1'b1; cyc();
    bus.pending_clr[3] = 1'b1; cyc(); bus.pending_clr[3] = 1'b0;
    chk("set_wins3", bus.pending[3], 1'b1);

    // Inverted level on a disabled channel, then suppress.
    bus.invert[7] = 1'b1; bus.mode[15:14] = 2'd0; bus.enable[7] = 1'b0;
    cyc(); cyc();
    chk("inv_int_out7", bus.int_out[7], 1'b1);
    chk("disabled_pend7", bus.pending[7], 1'b0);
    bus.suppress_set = 1'b1; cyc(); bus.suppress_set = 1'b0;
    chk("suppressed", bus.int_out, 64'd0);

    // Software wake cleared by a synchronised rising clear_function.
    bus.clear_edge = 2'd1;
    bus.wake_now_set = 1'b1; cyc(); bus.wake_now_set = 1'b0;
    chk("wake_now_set", bus.wake_now, 1'b1);
    bus.clear_function = 1'b1; cyc(); cyc();
    chk("wake_now_before_clr", bus.wake_now, 1'b1);
    cyc();
    chk("wake_now_cleared", bus.wake_now, 1'b0);
    chk("suppress_cleared", bus.event_suppress, 1'b0);
    bus.clear_edge = 2'd2;
    bus.wake_now_set = 1'b1; cyc(); bus.wake_now_set = 1'b0;
    bus.clear_function = 1'b0; repeat (4) cyc();
    bus.clear_function = 1'b1; repeat (5) cyc();
    chk("wake_now_no_clr", bus.wake_now, 1'b1);

    // Async reset mid-debounce and mid-hold.
    bus.deb_cycles = 8'd5; bus.int_in[2] = 1'b1; cyc(); cyc();
    chk("wake_before_rst", bus.wake, 1'b1);
    #3 sysreset_n = 1'b0;
    #1 check_zero("async_rst");
    m_reset();
    bus.int_in = '0; bus.invert = '0; bus.pending_clr = '0;
    bus.mode = {(N/2){4'b1110}}; bus.enable = '1; bus.deb_cycles = 8'd0;
    @(posedge clkclk); #2 sysreset_n = 1'b1;
    repeat (5) cyc();
    chk("no_pend_after_rst", bus.pending, 64'd0);

    // Randomised traffic against the reference.
    for (int c = 0; c < 400; c++) begin
      flip = N'($urandom) & N'($urandom);
      bus.int_in = bus.int_in ^ flip;
      if ($urandom_range(0, 19) == 0) bus.deb_cycles = DW'($urandom_range(0, 4));
      if ($urandom_range(0, 49) == 0) begin
        bus.mode   = (2*N)'($urandom);
        bus.enable = N'($urandom);
      end
      if ($urandom_range(0, 39) == 0) bus.invert = N'($urandom);
      bus.pending_clr  = N'($urandom) & N'($urandom) & N'($urandom);
      bus.wake_now_set = ($urandom_range(0, 29) == 0);
      bus.suppress_set = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 9) == 0) bus.clear_function = ~bus.clear_function;
      if ($urandom_range(0, 29) == 0) bus.clear_edge = 2'($urandom_range(0, 3));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
